// File: rtl/stage_d_pipe.sv
// Polaris instruction decode stage: latches one fetched instruction behind a
// valid/ready handshake and decodes it into ALU operands and memory controls.
module stage_d_pipe #(
  parameter int unsigned XLEN     = 64,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            f_ack_i,
  input  logic [31:0]     f_dat_i,
  input  logic [XLEN-1:0] f_pc_i,
  output logic            d_ready_o,
  input  logic            e_ready_i,
  output logic            d_valid_o,
  output logic [XLEN-1:0] d_pc_o,
  output logic [XLEN-1:0] d_vs1_o,
  output logic [XLEN-1:0] d_vs2_o,
  output logic [XLEN-1:0] d_vs3_o,
  output logic [4:0]      d_rd_o,
  output logic [3:0]      d_alu_o,
  output logic            d_mem_o,
  output logic            d_we_o,
  output logic [2:0]      d_size_o,
  output logic            d_illegal_o,
  output logic [4:0]      w_rs1_o,
  output logic [4:0]      w_rs2_o,
  input  logic [XLEN-1:0] w_dat1_i,
  input  logic [XLEN-1:0] w_dat2_i
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111
  } opcode_e;

  logic [31:0]     ir;
  logic [XLEN-1:0] pc;
  logic            v;

  assign d_ready_o = ~v | e_ready_i;
  assign d_valid_o = v;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ir <= NOP_INSN;
      pc <= '0;
      v  <= 1'b0;
    end else if (d_ready_o) begin
      ir <= f_ack_i ? f_dat_i : NOP_INSN;
      pc <= f_ack_i ? f_pc_i : '0;
      v  <= f_ack_i;
    end
  end

  logic [4:0]      rd;
  logic [2:0]      fn3;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
  logic            shift_ok;

  assign w_rs1_o = ir[19:15];
  assign w_rs2_o = ir[24:20];
  assign rd      = ir[11:7];
  assign fn3     = ir[14:12];

  assign imm_i = XLEN'($signed(ir[31:20]));
  assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
  assign imm_u = XLEN'($signed({ir[31:12], 12'h000}));

  // RV64 shifts take a 6-bit shamt, so legality only inspects funct6.
  assign shamt    = (XLEN == 64) ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);
  assign shift_ok = (XLEN == 64) ? (ir[31:26] == 6'b000000 || ir[31:26] == 6'b010000)
                                 : (ir[31:25] == 7'b0000000 || ir[31:25] == 7'b0100000);

  logic [4:0]      rd_dec;
  logic [XLEN-1:0] vs1_dec, vs2_dec;
  logic [3:0]      alu_dec;
  logic            mem_dec, we_dec, illegal;
  logic [2:0]      size_dec;

  always_comb begin
    rd_dec   = '0;
    vs1_dec  = '0;
    vs2_dec  = '0;
    alu_dec  = '0;
    mem_dec  = 1'b0;
    we_dec   = 1'b0;
    size_dec = '0;
    illegal  = 1'b0;
    case (ir[6:0])
      OPC_OP_IMM: begin
        rd_dec  = rd;
        vs1_dec = w_dat1_i;
        if (fn3 == 3'b001 || fn3 == 3'b101) begin
          vs2_dec = shamt;
          alu_dec = {ir[30], fn3};
          illegal = ~shift_ok;
        end else begin
          vs2_dec = imm_i;
          alu_dec = {1'b0, fn3};
        end
      end
      OPC_OP: begin
        rd_dec  = rd;
        vs1_dec = w_dat1_i;
        vs2_dec = w_dat2_i;
        alu_dec = {ir[30], fn3};
        illegal = !(ir[31:25] == 7'b0000000 ||
                    (ir[31:25] == 7'b0100000 && (fn3 == 3'b000 || fn3 == 3'b101)));
      end
      OPC_LUI: begin
        rd_dec  = rd;
        vs2_dec = imm_u;
      end
      OPC_AUIPC: begin
        rd_dec  = rd;
        vs1_dec = pc;
        vs2_dec = imm_u;
      end
      OPC_LOAD: begin
        rd_dec   = rd;
        vs1_dec  = w_dat1_i;
        vs2_dec  = imm_i;
        mem_dec  = 1'b1;
        size_dec = fn3;
        illegal  = (fn3 == 3'b111) ||
                   (XLEN == 32 && (fn3 == 3'b011 || fn3 == 3'b110));
      end
      OPC_STORE: begin
        vs1_dec  = w_dat1_i;
        vs2_dec  = imm_s;
        mem_dec  = 1'b1;
        we_dec   = 1'b1;
        size_dec = fn3;
        illegal  = fn3[2] || (XLEN == 32 && fn3 == 3'b011);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Bubbles and illegal encodings both collapse to an inert ADD with no side effects.
  always_comb begin
    d_rd_o   = '0;
    d_vs1_o  = '0;
    d_vs2_o  = '0;
    d_alu_o  = '0;
    d_mem_o  = 1'b0;
    d_we_o   = 1'b0;
    d_size_o = '0;
    if (v && !illegal) begin
      d_rd_o   = rd_dec;
      d_vs1_o  = vs1_dec;
      d_vs2_o  = vs2_dec;
      d_alu_o  = alu_dec;
      d_mem_o  = mem_dec;
      d_we_o   = we_dec;
      d_size_o = size_dec;
    end
  end

  assign d_illegal_o = v & illegal;
  assign d_vs3_o     = v ? w_dat2_i : '0;
  assign d_pc_o      = v ? pc : '0;

endmodule

// File: tb/tb_stage_d_pipe.sv
// Bench for stage_d_pipe: XLEN=64 and XLEN=32 instances share stimulus; directed
// vectors, stall/reset sequences and random traffic against a reference decoder.
module tb_stage_d_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, f_ack_i, e_ready_i;
  logic [31:0] f_dat_i;
  logic [63:0] f_pc_i, w_dat1_i, w_dat2_i;

  logic        r64, v64, mem64, we64, ill64;
  logic [63:0] pc64, vs1_64, vs2_64, vs3_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [3:0]  alu64;
  logic [2:0]  size64;

  logic        r32, v32, mem32, we32, ill32;
  logic [31:0] pc32, vs1_32, vs2_32, vs3_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [3:0]  alu32;
  logic [2:0]  size32;

  stage_d_pipe #(.XLEN(64), .NOP_INSN(NOP)) u_dut64 (
    .clk_i(clk), .reset_i(reset_i), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i), .f_pc_i(f_pc_i),
    .d_ready_o(r64), .e_ready_i(e_ready_i), .d_valid_o(v64), .d_pc_o(pc64),
    .d_vs1_o(vs1_64), .d_vs2_o(vs2_64), .d_vs3_o(vs3_64), .d_rd_o(rd64), .d_alu_o(alu64),
    .d_mem_o(mem64), .d_we_o(we64), .d_size_o(size64), .d_illegal_o(ill64),
    .w_rs1_o(rs1_64), .w_rs2_o(rs2_64), .w_dat1_i(w_dat1_i), .w_dat2_i(w_dat2_i)
  );

  stage_d_pipe #(.XLEN(32), .NOP_INSN(NOP)) u_dut32 (
    .clk_i(clk), .reset_i(reset_i), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i), .f_pc_i(f_pc_i[31:0]),
    .d_ready_o(r32), .e_ready_i(e_ready_i), .d_valid_o(v32), .d_pc_o(pc32),
    .d_vs1_o(vs1_32), .d_vs2_o(vs2_32), .d_vs3_o(vs3_32), .d_rd_o(rd32), .d_alu_o(alu32),
    .d_mem_o(mem32), .d_we_o(we32), .d_size_o(size32), .d_illegal_o(ill32),
    .w_rs1_o(rs1_32), .w_rs2_o(rs2_32), .w_dat1_i(w_dat1_i[31:0]), .w_dat2_i(w_dat2_i[31:0])
  );

  typedef struct packed {
    logic        valid, ready;
    logic [63:0] pc, vs1, vs2, vs3;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        mem, we;
    logic [2:0]  size;
    logic        ill;
    logic [4:0]  rs1, rs2;
  } exp_t;

  typedef struct {
    logic [31:0] insn;
    logic [63:0] pc, r1, r2, vs1, vs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        mem, we;
    logic [2:0]  size;
    logic        ill, ill_32;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Architectural state of the stage as the bench understands it.
  logic        mv;
  logic [31:0] mir;
  logic [63:0] mpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t ref_dec(input logic v, input logic rdy, input logic [31:0] i,
                                   input logic [63:0] pc, input logic [63:0] r1,
                                   input logic [63:0] r2, input int xl);
    exp_t e;
    logic [63:0] m;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        ok;
    longint      si, ss, su;
    e = '0;
    e.valid = v;
    e.ready = rdy;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    if (!v) return e;
    m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    si = longint'($signed(i[31:20]));
    ss = longint'($signed({i[31:25], i[11:7]}));
    su = longint'($signed({i[31:12], 12'h000}));
    e.pc  = pc & m;
    e.vs3 = r2 & m;
    e.rd  = i[11:7];
    ok = 1'b1;
    case (op)
      7'h13: begin
        e.vs1 = r1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.vs2 = (xl == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
          e.alu = {i[30], f3};
          ok = (xl == 64) ? (i[31:26] == 6'h00 || i[31:26] == 6'h10) : (f7 == 7'h00 || f7 == 7'h20);
        end else begin
          e.vs2 = si;
          e.alu = {1'b0, f3};
        end
      end
      7'h33: begin
        e.vs1 = r1;
        e.vs2 = r2;
        e.alu = {i[30], f3};
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h37: e.vs2 = su;
      7'h17: begin e.vs1 = pc; e.vs2 = su; end
      7'h03: begin
        e.vs1 = r1; e.vs2 = si; e.mem = 1'b1; e.size = f3;
        ok = (f3 != 3'd7) && !(xl == 32 && (f3 == 3'd3 || f3 == 3'd6));
      end
      7'h23: begin
        e.rd = '0; e.vs1 = r1; e.vs2 = ss; e.mem = 1'b1; e.we = 1'b1; e.size = f3;
        ok = (f3 < 3'd3) || (f3 == 3'd3 && xl == 64);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.rd = '0; e.vs1 = '0; e.vs2 = '0; e.alu = '0;
      e.mem = 1'b0; e.we = 1'b0; e.size = '0; e.ill = 1'b1;
    end
    e.vs1 = e.vs1 & m;
    e.vs2 = e.vs2 & m;
    return e;
  endfunction

  function automatic exp_t got64();
    exp_t g;
    g = '{valid: v64, ready: r64, pc: pc64, vs1: vs1_64, vs2: vs2_64, vs3: vs3_64, rd: rd64,
          alu: alu64, mem: mem64, we: we64, size: size64, ill: ill64, rs1: rs1_64, rs2: rs2_64};
    return g;
  endfunction

  function automatic exp_t got32();
    exp_t g;
    g = '{valid: v32, ready: r32, pc: 64'(pc32), vs1: 64'(vs1_32), vs2: 64'(vs2_32),
          vs3: 64'(vs3_32), rd: rd32, alu: alu32, mem: mem32, we: we32, size: size32,
          ill: ill32, rs1: rs1_32, rs2: rs2_32};
    return g;
  endfunction

  task automatic cmp(input string tag, input exp_t g, input exp_t e);
    chk({tag, ".valid"}, 64'(g.valid), 64'(e.valid));
    chk({tag, ".ready"}, 64'(g.ready), 64'(e.ready));
    chk({tag, ".pc"},    g.pc, e.pc);
    chk({tag, ".vs1"},   g.vs1, e.vs1);
    chk({tag, ".vs2"},   g.vs2, e.vs2);
    chk({tag, ".vs3"},   g.vs3, e.vs3);
    chk({tag, ".rd"},    64'(g.rd), 64'(e.rd));
    chk({tag, ".alu"},   64'(g.alu), 64'(e.alu));
    chk({tag, ".mem"},   64'(g.mem), 64'(e.mem));
    chk({tag, ".we"},    64'(g.we), 64'(e.we));
    chk({tag, ".size"},  64'(g.size), 64'(e.size));
    chk({tag, ".ill"},   64'(g.ill), 64'(e.ill));
    chk({tag, ".rs1"},   64'(g.rs1), 64'(e.rs1));
    chk({tag, ".rs2"},   64'(g.rs2), 64'(e.rs2));
  endtask

  task automatic check_all(input string tag);
    logic rdy;
    rdy = !mv || e_ready_i;
    cmp({tag, "64"}, got64(), ref_dec(mv, rdy, mir, mpc, w_dat1_i, w_dat2_i, 64));
    cmp({tag, "32"}, got32(), ref_dec(mv, rdy, mir, mpc, w_dat1_i, w_dat2_i, 32));
  endtask

  task automatic model_edge();
    if (!reset_i) begin
      mv = 1'b0; mir = NOP; mpc = '0;
    end else if (!mv || e_ready_i) begin
      mv  = f_ack_i;
      mir = f_ack_i ? f_dat_i : NOP;
      mpc = f_ack_i ? f_pc_i : 64'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 6))
      0: x[6:0] = 7'h03;
      1: x[6:0] = 7'h13;
      2: x[6:0] = 7'h17;
      3: x[6:0] = 7'h23;
      4: x[6:0] = 7'h33;
      5: x[6:0] = 7'h37;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      2: x[31:26] = 6'h10;
      default: ;
    endcase
    return x;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{32'hFFC18113, 64'h100, 64'h0011223344556677, 64'h5, 64'h0011223344556677,
                64'hFFFF_FFFF_FFFF_FFFC, 5'd2, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{32'h407302B3, 64'h104, 64'd20, 64'd9, 64'd20, 64'd9, 5'd5, 4'h8,
                1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{32'h4211D113, 64'h108, 64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000,
                64'd33, 5'd2, 4'hD, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{32'h0040B423, 64'h10C, 64'h1000, 64'hDEAD_BEEF_CAFE_F00D, 64'h1000, 64'd8,
                5'd0, 4'h0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1};
    tbl[4]  = '{32'h00012083, 64'h110, 64'h2000, 64'h7, 64'h2000, 64'h0, 5'd1, 4'h0,
                1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
    tbl[5]  = '{32'h12345097, 64'h2000, 64'hAAAA, 64'h0, 64'h2000, 64'h12345000, 5'd1, 4'h0,
                1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{32'h800001B7, 64'h2004, 64'h5555, 64'h1, 64'h0, 64'hFFFF_FFFF_8000_0000, 5'd3,
                4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000007F, 64'h2008, 64'h1234, 64'h77, 64'h0, 64'h0, 5'd0, 4'h0,
                1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[8]  = '{32'h02000033, 64'h200C, 64'h1, 64'h2, 64'h0, 64'h0, 5'd0, 4'h0,
                1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[9]  = '{32'h40001033, 64'h2010, 64'h3, 64'h4, 64'h0, 64'h0, 5'd0, 4'h0,
                1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{32'h00007003, 64'h2014, 64'h5, 64'h6, 64'h0, 64'h0, 5'd0, 4'h0,
                1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[11] = '{32'h00004023, 64'h2018, 64'h7, 64'h8, 64'h0, 64'h0, 5'd0, 4'h0,
                1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[12] = '{32'h03F09093, 64'h201C, 64'h1, 64'h0, 64'h1, 64'd63, 5'd1, 4'h1,
                1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[13] = '{32'hFFF0C093, 64'h2020, 64'hF0F0, 64'h0, 64'hF0F0, 64'hFFFF_FFFF_FFFF_FFFF,
                5'd1, 4'h4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[14] = '{32'h00013083, 64'h2024, 64'h3000, 64'h9, 64'h3000, 64'h0, 5'd1, 4'h0,
                1'b1, 1'b0, 3'd3, 1'b0, 1'b1};

    mv = 1'b0; mir = NOP; mpc = '0;

    // Reset wins over a pending accept even with the execute stage stalled.
    reset_i = 1'b0; f_ack_i = 1'b1; f_dat_i = 32'h0040B423; f_pc_i = 64'h40;
    e_ready_i = 1'b0; w_dat1_i = 64'h1111; w_dat2_i = 64'h99;
    tick();
    chk("rst.valid", 64'(v64), 64'h0);
    chk("rst.ready", 64'(r64), 64'h1);
    chk("rst.pc", pc64, 64'h0);
    chk("rst.vs1", vs1_64, 64'h0);
    chk("rst.vs2", vs2_64, 64'h0);
    chk("rst.vs3", vs3_64, 64'h0);
    chk("rst.rd", 64'(rd64), 64'h0);
    chk("rst.alu", 64'(alu64), 64'h0);
    chk("rst.mem", 64'({mem64, we64}), 64'h0);
    chk("rst.ill", 64'(ill64), 64'h0);
    chk("rst.rs", 64'({rs1_64, rs2_64}), 64'h0);
    check_all("rst");
    reset_i = 1'b1; f_ack_i = 1'b0;
    tick();
    chk("idle.valid", 64'(v64), 64'h0);
    chk("idle.ready", 64'(r64), 64'h1);
    check_all("idle");

    e_ready_i = 1'b1;
    foreach (tbl[k]) begin
      f_ack_i = 1'b1; f_dat_i = tbl[k].insn; f_pc_i = tbl[k].pc;
      w_dat1_i = tbl[k].r1; w_dat2_i = tbl[k].r2;
      tick();
      chk("tv.valid", 64'(v64), 64'h1);
      chk("tv.pc", pc64, tbl[k].pc);
      chk("tv.vs1", vs1_64, tbl[k].vs1);
      chk("tv.vs2", vs2_64, tbl[k].vs2);
      chk("tv.vs3", vs3_64, tbl[k].r2);
      chk("tv.rd", 64'(rd64), 64'(tbl[k].rd));
      chk("tv.alu", 64'(alu64), 64'(tbl[k].alu));
      chk("tv.mem", 64'(mem64), 64'(tbl[k].mem));
      chk("tv.we", 64'(we64), 64'(tbl[k].we));
      chk("tv.size", 64'(size64), 64'(tbl[k].size));
      chk("tv.ill", 64'(ill64), 64'(tbl[k].ill));
      chk("tv.ill32", 64'(ill32), 64'(tbl[k].ill_32));
      check_all("tv");
    end

    // Stall: held outputs, F words ignored, then release and reset mid-stall.
    f_ack_i = 1'b1; e_ready_i = 1'b1; f_dat_i = 32'hFFC18113; f_pc_i = 64'h300;
    w_dat1_i = 64'h11; w_dat2_i = 64'h22;
    tick();
    chk("stl.load.rd", 64'(rd64), 64'd2);
    e_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      f_dat_i = rand_insn(); f_pc_i = {$urandom, $urandom};
      tick();
      chk("stl.ready", 64'(r64), 64'h0);
      chk("stl.valid", 64'(v64), 64'h1);
      chk("stl.pc", pc64, 64'h300);
      chk("stl.rd", 64'(rd64), 64'd2);
      chk("stl.vs2", vs2_64, 64'hFFFF_FFFF_FFFF_FFFC);
      check_all("stl");
    end
    e_ready_i = 1'b1; f_dat_i = 32'h407302B3; f_pc_i = 64'h304; w_dat2_i = 64'd9;
    #1;
    chk("rel.ready", 64'(r64), 64'h1);
    tick();
    chk("rel.pc", pc64, 64'h304);
    chk("rel.rd", 64'(rd64), 64'd5);
    chk("rel.alu", 64'(alu64), 64'h8);
    chk("rel.vs2", vs2_64, 64'd9);
    e_ready_i = 1'b0; reset_i = 1'b0;
    tick();
    chk("srst.valid", 64'(v64), 64'h0);
    chk("srst.ready", 64'(r64), 64'h1);
    chk("srst.rd", 64'(rd64), 64'h0);
    check_all("srst");
    reset_i = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      reset_i   = ($urandom_range(0, 40) != 0);
      f_ack_i   = ($urandom_range(0, 3) != 0);
      e_ready_i = ($urandom_range(0, 2) != 0);
      f_dat_i   = rand_insn();
      f_pc_i    = {$urandom, $urandom};
      w_dat1_i  = {$urandom, $urandom};
      w_dat2_i  = {$urandom, $urandom};
      #1;
      check_all("rnd");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage_d_pipe.md
Name: stage_d_pipe

Overview:
Second-generation instruction decode stage for the Polaris pipeline, parametrised in XLEN (32 or 64).
- Adds a valid/ready stall handshake toward the execute stage.
- Adds a second register read port and carries the instruction PC.
- Decodes OP, OP-IMM, LUI, AUIPC, LOAD and STORE, and flags illegal encodings.
- Sits between the fetch (F) bus and the execute stage; reads the register file through the W-stage ports.

Parameters:
XLEN, 64, datapath width; legal values 32 and 64.
NOP_INSN, 32'h00000013, encoding loaded into IR for bubbles (ADDI X0,X0,0).

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous reset, active-low
f_ack_i  in  1  f_dat_i/f_pc_i valid
f_dat_i  in  32  fetched instruction
f_pc_i  in  XLEN  address of f_dat_i
d_ready_o  out  1  stage accepts a new instruction this cycle
e_ready_i  in  1  execute stage accepts current decode output
d_valid_o  out  1  decode outputs hold a real instruction
d_pc_o  out  XLEN  PC of decoded instruction
d_vs1_o  out  XLEN  ALU operand 1
d_vs2_o  out  XLEN  ALU operand 2
d_vs3_o  out  XLEN  store data (rs2 value)
d_rd_o  out  5  destination register, 0 if none
d_alu_o  out  4  ALU code per rtl/verilog/alu.vh, {sign, fn3}
d_mem_o  out  1  memory access
d_we_o  out  1  memory write (store)
d_size_o  out  3  fn3 of load/store, else 0
d_illegal_o  out  1  unsupported/illegal encoding
w_rs1_o  out  5  register file read address 1
w_rs2_o  out  5  register file read address 2
w_dat1_i  in  XLEN  register file data, port 1
w_dat2_i  in  XLEN  register file data, port 2

Behaviour:
- State registers: IR (32), PC (XLEN), V (valid bit).
- Handshake:
  - d_ready_o = ~V | e_ready_i, combinational.
  - d_valid_o = V.
  - Accept occurs when d_ready_o & f_ack_i.
- Rising edge with reset_i=0: IR<=NOP_INSN, PC<=0, V<=0. Reset overrides any accept.
- Rising edge with d_ready_o=1: IR<=f_ack_i?f_dat_i:NOP_INSN; PC<=f_ack_i?f_pc_i:0; V<=f_ack_i.
- Rising edge with d_ready_o=0: IR, PC and V hold. Outputs remain stable while stalled; F data is ignored.
- Latency: an instruction accepted at edge N is presented during cycle N+1.
- Field decode, combinational from IR:
  - rs1 = IR[19:15], rs2 = IR[24:20], rd = IR[11:7], fn3 = IR[14:12].
- Immediates, all sign-extended to XLEN from IR[31]:
  - I: IR[31:20].
  - S: {IR[31:25], IR[11:7]}.
  - U: {IR[31:12], 12'b0}.
  - Shift amount: IR[25:20] zero-extended for XLEN=64; IR[24:20] for XLEN=32.
- OP-IMM (0010011): vs1=rs1 value, vs2=I-imm.
  - For shifts (fn3 001/101): vs2=shamt, alu={IR[30],fn3}.
  - For all other fn3: alu={0,fn3}.
- OP (0110011): vs1=rs1 value, vs2=rs2 value, alu={IR[30],fn3}.
- LUI (0110111): vs1=0, vs2=U-imm, alu=ADD.
- AUIPC (0010111): vs1=PC, vs2=U-imm, alu=ADD.
- LOAD (0000011): vs1=rs1 value, vs2=I-imm, alu=ADD, mem=1, we=0, size=fn3.
- STORE (0100011): vs1=rs1 value, vs2=S-imm, vs3=rs2 value, rd=0, alu=ADD, mem=1, we=1, size=fn3.
- d_vs3_o = rs2 value for every instruction; it is only meaningful for stores.
- Illegal (d_illegal_o=1) when any of:
  - opcode not listed above;
  - OP with IR[31:25] not in {0000000, 0100000}, or IR[30]=1 with fn3 not 000/101;
  - OP-IMM shift with IR[31:26] other than 000000/010000 (XLEN=64), or IR[31:25] other than 0000000/0100000 (XLEN=32);
  - LOAD fn3=111; STORE fn3[2]=1;
  - XLEN=32 and LOAD fn3 in {011, 110}, or STORE fn3=011.
- Illegal forcing: rd=0, mem=0, we=0, vs1=vs2=0, alu=ADD, size=0; d_valid_o still reflects V.
- Bubble (V=0): rd=0, vs1=0, vs2=0, vs3=0, alu=ADD, mem=0, we=0, size=0, illegal=0, pc=0.
  - w_rs1_o and w_rs2_o follow IR, so they read 0 during a bubble.
- Reset mid-stall: the next edge with reset_i=0 clears V regardless of e_ready_i.

Test Plan:
- Reset then stall-free NOP stream: reset_i=0 one cycle, then f_ack_i=0 -> d_valid_o=0 and all bubble values, d_ready_o=1.
- ADDI X2,X3,-4 (0xFFC18113), f_pc_i=0x100, w_dat1_i=0x0011223344556677 -> next cycle d_valid_o=1, rd=2, w_rs1_o=3, vs1=0x0011223344556677, vs2=all-ones-minus-3, alu=ADD, pc=0x100.
- SUB X5,X6,X7 (0x407302B3), w_dat2_i=9 -> vs2=9, alu=SUB ({1,000}), w_rs2_o=7; SRAI X2,X3,33 on XLEN=64 -> vs2=33, alu=SRA; same on XLEN=32 -> illegal=1, rd=0.
- SD X4,8(X1) (0x0040B423) -> mem=1, we=1, size=3, vs2=8, vs3=w_dat2_i, rd=0; LW X1,0(X2) -> mem=1, we=0, size=2, rd=1.
- AUIPC X1,0x12345 at pc 0x2000 -> vs1=0x2000, vs2=0x12345000, rd=1; LUI with IR[31]=1 on XLEN=64 -> vs2 upper 32 bits all ones.
- Stall: hold e_ready_i=0 for 3 cycles while F presents new words -> d_ready_o=0, outputs unchanged; raise e_ready_i -> next F word decoded; assert reset_i=0 while stalled -> d_valid_o=0 next cycle.
